// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
// Handshake: the master raises dmem_req with addr/we/be/wdata stable and holds
// them until the slave answers with dmem_ready=1. That cycle completes the
// access, and dmem_rdata is valid only in that cycle.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory bus, stalls upstream while an
// access is outstanding, aborts on timeout and registers the MEM/WB boundary.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic        RegWrite_MEM,
  input  logic        MemtoReg_MEM,
  input  logic [4:0]  RD_MEM,
  input  logic [31:0] ALU_OUT_MEM,
  input  logic [31:0] REG2_DATA_MEM,
  input  logic [2:0]  FUNCT3_MEM,
  mem_stage_if.master dmem,
  output logic        stall_mem,
  output logic        RegWrite_WB,
  output logic        MemtoReg_WB,
  output logic [4:0]  RD_WB,
  output logic [31:0] ALU_OUT_WB,
  output logic [31:0] MEM_DATA_WB,
  output logic        misaligned_WB,
  output logic        bus_err_WB,
  output logic [0:0]  o_dbg_state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;

  logic        w_access;
  logic        w_mis_raw;
  logic        w_mis_evt;
  logic        w_req;
  logic        w_abort;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_ext;

  assign w_access = MemRead_MEM | MemWrite_MEM;

  // FUNCT3[1:0]: 00 byte, 01 half, anything else treated as a word access.
  always_comb begin
    w_mis_raw = 1'b0;
    w_be      = 4'b1111;
    w_wdata   = REG2_DATA_MEM;
    case (FUNCT3_MEM[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ALU_OUT_MEM[1:0];
        w_wdata = {4{REG2_DATA_MEM[7:0]}};
      end
      2'b01: begin
        w_mis_raw = ALU_OUT_MEM[0];
        w_be      = ALU_OUT_MEM[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{REG2_DATA_MEM[15:0]}};
      end
      default: w_mis_raw = (ALU_OUT_MEM[1:0] != 2'b00);
    endcase
  end

  assign w_lane = dmem.dmem_rdata >> {ALU_OUT_MEM[1:0], 3'b000};

  always_comb begin
    w_ext = dmem.dmem_rdata;
    case (FUNCT3_MEM)
      3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_ext = {24'd0, w_lane[7:0]};
      3'b101:  w_ext = {16'd0, w_lane[15:0]};
      default: w_ext = dmem.dmem_rdata;
    endcase
  end

  // In WAIT the upstream inputs are frozen, so they stay aligned and valid.
  assign w_mis_evt = (r_state == S_IDLE) & w_access & w_mis_raw;
  assign w_req     = reset & ((r_state == S_WAIT) | (w_access & ~w_mis_raw));
  assign w_abort   = (TIMEOUT_CYCLES != 0) && (r_state == S_WAIT) &&
                     !dmem.dmem_ready && (r_cnt == TO_VAL);

  assign dmem.dmem_req   = w_req;
  assign dmem.dmem_we    = w_req & MemWrite_MEM;
  assign dmem.dmem_addr  = {ALU_OUT_MEM[31:2], 2'b00};
  assign dmem.dmem_wdata = w_wdata;
  assign dmem.dmem_be    = w_be;
  assign stall_mem       = w_req & ~dmem.dmem_ready & ~w_abort;
  assign o_dbg_state     = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_req && !dmem.dmem_ready) begin
        r_state <= S_WAIT;
        r_cnt   <= CNT_W'(1);
      end
    end else if (dmem.dmem_ready || w_abort) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWrite_WB   <= 1'b0;
      MemtoReg_WB   <= 1'b0;
      RD_WB         <= '0;
      ALU_OUT_WB    <= '0;
      MEM_DATA_WB   <= '0;
      misaligned_WB <= 1'b0;
      bus_err_WB    <= 1'b0;
    end else if (stall_mem) begin
      // Bubble: data fields are held, only the enables drop.
      RegWrite_WB   <= 1'b0;
      misaligned_WB <= 1'b0;
      bus_err_WB    <= 1'b0;
    end else begin
      MemtoReg_WB   <= MemtoReg_MEM;
      RD_WB         <= RD_MEM;
      ALU_OUT_WB    <= ALU_OUT_MEM;
      misaligned_WB <= w_mis_evt;
      bus_err_WB    <= w_abort;
      RegWrite_WB   <= RegWrite_MEM & ~MemWrite_MEM & ~w_mis_evt & ~w_abort;
      MEM_DATA_WB   <= (MemRead_MEM & ~MemWrite_MEM & ~w_mis_evt & ~w_abort)
                       ? w_ext : 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: driver pushes expected WB records, a monitor
// pops one per clock and compares; bus-side outputs are checked inline.
module tb_mem_stage;
  localparam int W = 73;

  logic        clk;
  logic        reset;
  logic        mr, mw, rw, mtr;
  logic [4:0]  rd;
  logic [31:0] alu, r2;
  logic [2:0]  f3;
  logic        stall_mem;
  logic        RegWrite_WB, MemtoReg_WB, misaligned_WB, bus_err_WB;
  logic [4:0]  RD_WB;
  logic [31:0] ALU_OUT_WB, MEM_DATA_WB;
  logic [0:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  int n_chk = 0;
  int n_err = 0;
  int n_rec = 0;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .MemRead_MEM   (mr),
    .MemWrite_MEM  (mw),
    .RegWrite_MEM  (rw),
    .MemtoReg_MEM  (mtr),
    .RD_MEM        (rd),
    .ALU_OUT_MEM   (alu),
    .REG2_DATA_MEM (r2),
    .FUNCT3_MEM    (f3),
    .dmem          (bus),
    .stall_mem     (stall_mem),
    .RegWrite_WB   (RegWrite_WB),
    .MemtoReg_WB   (MemtoReg_WB),
    .RD_WB         (RD_WB),
    .ALU_OUT_WB    (ALU_OUT_WB),
    .MEM_DATA_WB   (MEM_DATA_WB),
    .misaligned_WB (misaligned_WB),
    .bus_err_WB    (bus_err_WB),
    .o_dbg_state   (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic op(input logic i_mr, input logic i_mw, input logic i_rw, input logic i_mtr,
                    input logic [4:0] i_rd, input logic [31:0] i_alu, input logic [31:0] i_r2,
                    input logic [2:0] i_f3, input logic i_rdy, input logic [31:0] i_rdata);
    mr = i_mr; mw = i_mw; rw = i_rw; mtr = i_mtr;
    rd = i_rd; alu = i_alu; r2 = i_r2; f3 = i_f3;
    bus.dmem_ready = i_rdy;
    bus.dmem_rdata = i_rdata;
  endtask

  task automatic idle();
    op(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 3'd0, 0, 32'd0);
  endtask

  task automatic exp_wb(input logic e_rw, input logic e_mtr, input logic [4:0] e_rd,
                        input logic [31:0] e_alu, input logic [31:0] e_data,
                        input logic e_mis, input logic e_berr, input logic cm, input logic cd);
    exp_q.push_back({e_rw, e_mtr, e_rd, e_alu, e_data, e_mis, e_berr});
    msk_q.push_back({1'b1, cm, {5{cm}}, {32{cm}}, {32{cd}}, 1'b1, 1'b1});
  endtask

  task automatic bubble();
    exp_wb(0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 0, 0);
  endtask

  task automatic idle_cycle();
    idle();
    #1;
    exp_wb(0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 1, 1);
    @(negedge clk);
  endtask

  // Monitor / scoreboard
  always @(posedge clk) begin
    logic [W-1:0] act, e, m;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      act = {RegWrite_WB, MemtoReg_WB, RD_WB, ALU_OUT_WB, MEM_DATA_WB, misaligned_WB, bus_err_WB};
      n_chk++;
      if ((act & m) !== (e & m)) begin
        n_err++;
        $display("FAIL wb[%0d]: got %h want %h (mask %h)", n_rec, act, e, m);
      end
      n_rec++;
    end
  end

  // Stimulus
  initial begin
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_regwrite", {31'd0, RegWrite_WB}, 32'd0);
    chk("rst_alu_wb", ALU_OUT_WB, 32'd0);
    chk("rst_state", {31'd0, dbg_state}, 32'd0);
    reset = 1'b1;

    // LW 0x100, zero-wait
    op(1, 0, 1, 1, 5'd5, 32'h100, 32'd0, 3'b010, 1, 32'hDEADBEEF);
    #1;
    chk("lw_req", {31'd0, bus.dmem_req}, 32'd1);
    chk("lw_stall", {31'd0, stall_mem}, 32'd0);
    chk("lw_addr", bus.dmem_addr, 32'h100);
    chk("lw_be", {28'd0, bus.dmem_be}, 32'hF);
    chk("lw_we", {31'd0, bus.dmem_we}, 32'd0);
    exp_wb(1, 1, 5'd5, 32'h100, 32'hDEADBEEF, 0, 0, 1, 1);
    @(negedge clk);

    // LB 0x103 with three wait cycles
    for (int i = 0; i < 3; i++) begin
      op(1, 0, 1, 1, 5'd6, 32'h103, 32'd0, 3'b000, 0, 32'd0);
      #1;
      chk("lb_stall", {31'd0, stall_mem}, 32'd1);
      chk("lb_be", {28'd0, bus.dmem_be}, 32'h8);
      if (i > 0) chk("lb_state", {31'd0, dbg_state}, 32'd1);
      bubble();
      @(negedge clk);
    end
    op(1, 0, 1, 1, 5'd6, 32'h103, 32'd0, 3'b000, 1, 32'h80FFFF00);
    #1;
    chk("lb_done_stall", {31'd0, stall_mem}, 32'd0);
    chk("lb_done_be", {28'd0, bus.dmem_be}, 32'h8);
    exp_wb(1, 1, 5'd6, 32'h103, 32'hFFFFFF80, 0, 0, 1, 1);
    @(negedge clk);

    // SH 0x102 with RegWrite set: must not write a register
    op(0, 1, 1, 0, 5'd7, 32'h102, 32'h1234ABCD, 3'b001, 1, 32'd0);
    #1;
    chk("sh_we", {31'd0, bus.dmem_we}, 32'd1);
    chk("sh_be", {28'd0, bus.dmem_be}, 32'hC);
    chk("sh_wdata", bus.dmem_wdata, 32'hABCDABCD);
    chk("sh_stall", {31'd0, stall_mem}, 32'd0);
    exp_wb(0, 0, 5'd7, 32'h102, 32'd0, 0, 0, 1, 1);
    @(negedge clk);

    // SB 0x101
    op(0, 1, 0, 0, 5'd7, 32'h101, 32'h000000EE, 3'b000, 1, 32'd0);
    #1;
    chk("sb_be", {28'd0, bus.dmem_be}, 32'h2);
    chk("sb_wdata", bus.dmem_wdata, 32'hEEEEEEEE);
    exp_wb(0, 0, 5'd7, 32'h101, 32'd0, 0, 0, 1, 1);
    @(negedge clk);

    // Read and write both set: store wins
    op(1, 1, 1, 1, 5'd11, 32'h200, 32'h55AA00FF, 3'b010, 1, 32'hFFFFFFFF);
    #1;
    chk("rw_we", {31'd0, bus.dmem_we}, 32'd1);
    chk("rw_wdata", bus.dmem_wdata, 32'h55AA00FF);
    exp_wb(0, 1, 5'd11, 32'h200, 32'd0, 0, 0, 1, 1);
    @(negedge clk);

    // LH / LHU / LBU extension
    op(1, 0, 1, 1, 5'd12, 32'h102, 32'd0, 3'b001, 1, 32'h80011234);
    #1; exp_wb(1, 1, 5'd12, 32'h102, 32'hFFFF8001, 0, 0, 1, 1);
    @(negedge clk);
    op(1, 0, 1, 1, 5'd12, 32'h102, 32'd0, 3'b101, 1, 32'h80011234);
    #1; exp_wb(1, 1, 5'd12, 32'h102, 32'h00008001, 0, 0, 1, 1);
    @(negedge clk);
    op(1, 0, 1, 1, 5'd12, 32'h101, 32'd0, 3'b100, 1, 32'h0000AB00);
    #1; exp_wb(1, 1, 5'd12, 32'h101, 32'h000000AB, 0, 0, 1, 1);
    @(negedge clk);

    // Non-memory ALU op
    op(0, 0, 1, 0, 5'd13, 32'h12345678, 32'd0, 3'b000, 0, 32'd0);
    #1;
    chk("alu_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("alu_stall", {31'd0, stall_mem}, 32'd0);
    exp_wb(1, 0, 5'd13, 32'h12345678, 32'd0, 0, 0, 1, 1);
    @(negedge clk);

    // Misaligned LW 0x101
    op(1, 0, 1, 1, 5'd14, 32'h101, 32'd0, 3'b010, 0, 32'd0);
    #1;
    chk("mis_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("mis_stall", {31'd0, stall_mem}, 32'd0);
    exp_wb(0, 0, 5'd0, 32'd0, 32'd0, 1, 0, 0, 0);
    @(negedge clk);
    idle_cycle();

    // Timeout: ready never arrives
    for (int i = 0; i < 4; i++) begin
      op(1, 0, 1, 1, 5'd15, 32'h300, 32'd0, 3'b010, 0, 32'd0);
      #1;
      chk("to_stall", {31'd0, stall_mem}, 32'd1);
      bubble();
      @(negedge clk);
    end
    op(1, 0, 1, 1, 5'd15, 32'h300, 32'd0, 3'b010, 0, 32'd0);
    #1;
    chk("to_abort_stall", {31'd0, stall_mem}, 32'd0);
    chk("to_abort_req", {31'd0, bus.dmem_req}, 32'd1);
    exp_wb(0, 0, 5'd0, 32'd0, 32'd0, 0, 1, 0, 1);
    @(negedge clk);
    idle();
    #1;
    chk("to_idle_state", {31'd0, dbg_state}, 32'd0);
    exp_wb(0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 1, 1);
    @(negedge clk);

    // Ready on the same cycle the timeout is reached: completes normally
    for (int i = 0; i < 4; i++) begin
      op(1, 0, 1, 1, 5'd15, 32'h300, 32'd0, 3'b010, 0, 32'd0);
      #1; bubble();
      @(negedge clk);
    end
    op(1, 0, 1, 1, 5'd15, 32'h300, 32'd0, 3'b010, 1, 32'h11223344);
    #1;
    chk("tr_stall", {31'd0, stall_mem}, 32'd0);
    exp_wb(1, 1, 5'd15, 32'h300, 32'h11223344, 0, 0, 1, 1);
    @(negedge clk);
    idle_cycle();

    // Reset asserted mid-WAIT
    op(1, 0, 1, 1, 5'd9, 32'h500, 32'd0, 3'b010, 1, 32'hCAFEF00D);
    #1; exp_wb(1, 1, 5'd9, 32'h500, 32'hCAFEF00D, 0, 0, 1, 1);
    @(negedge clk);
    op(1, 0, 1, 1, 5'd16, 32'h404, 32'd0, 3'b010, 0, 32'd0);
    #1;
    chk("rw_pre_stall", {31'd0, stall_mem}, 32'd1);
    bubble();
    @(negedge clk);
    #1;
    chk("rw_pre_state", {31'd0, dbg_state}, 32'd1);
    bubble();
    @(negedge clk);
    chk("rw_held_alu", ALU_OUT_WB, 32'h500);
    chk("rw_held_data", MEM_DATA_WB, 32'hCAFEF00D);
    reset = 1'b0;
    #1;
    chk("ar_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("ar_stall", {31'd0, stall_mem}, 32'd0);
    chk("ar_alu_wb", ALU_OUT_WB, 32'd0);
    chk("ar_data_wb", MEM_DATA_WB, 32'd0);
    chk("ar_rd_wb", {27'd0, RD_WB}, 32'd0);
    chk("ar_mtr_wb", {31'd0, MemtoReg_WB}, 32'd0);
    chk("ar_state", {31'd0, dbg_state}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    op(1, 0, 1, 1, 5'd10, 32'h600, 32'd0, 3'b010, 1, 32'h0BADCAFE);
    #1;
    chk("post_req", {31'd0, bus.dmem_req}, 32'd1);
    chk("post_stall", {31'd0, stall_mem}, 32'd0);
    exp_wb(1, 1, 5'd10, 32'h600, 32'h0BADCAFE, 0, 0, 1, 1);
    @(negedge clk);
    idle_cycle();
    @(negedge clk);

    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
